pipe_idex_operand_stage: RTL and testbench

- ID/EX pipeline register of the pipelined MIPS core, directly upstream of the EX-stage ALU.
- Captures decoded operands and control at the ID/EX boundary.
- Resolves data forwarding from EX/MEM and MEM/WB.
- Drives the ALU's a, b and aluc inputs, plus the store-data and writeback control carried forward to EX/MEM.

---
 rtl/pipe_idex_operand_stage_if.sv | 55 +++++
 rtl/pipe_idex_operand_stage.sv | 128 ++++++++++++
 tb/tb_pipe_idex_operand_stage.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_idex_operand_stage_if.sv
// Signal bundle around the ID/EX operand stage: decoded ID fields, the EX/MEM and MEM/WB
// forwarding sources, and the operands and controls handed to EX.
interface pipe_idex_operand_stage_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_qa;
  logic [31:0] id_qb;
  logic [31:0] id_imm;
  logic [4:0]  id_sa;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_wn;
  logic [3:0]  id_aluc;
  logic        id_aluimm;
  logic        id_shift;
  logic        id_wreg;
  logic        id_m2reg;
  logic        id_wmem;
  logic        em_wreg;
  logic        em_m2reg;
  logic [4:0]  em_wn;
  logic [31:0] em_alu;
  logic        mw_wreg;
  logic [4:0]  mw_wn;
  logic [31:0] mw_result;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [3:0]  ex_aluc;
  logic [31:0] ex_st_data;
  logic [4:0]  ex_wn;
  logic        ex_valid;
  logic        ex_wreg;
  logic        ex_m2reg;
  logic        ex_wmem;
  logic [1:0]  ex_fwd_a;
  logic [1:0]  ex_fwd_b;

  // master: the pipeline around the stage (ID, hazard unit, EX/MEM, MEM/WB)
  modport master (
    output stall, flush, id_valid, id_qa, id_qb, id_imm, id_sa, id_rs, id_rt, id_wn,
           id_aluc, id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem,
           em_wreg, em_m2reg, em_wn, em_alu, mw_wreg, mw_wn, mw_result,
    input  ex_a, ex_b, ex_aluc, ex_st_data, ex_wn, ex_valid, ex_wreg, ex_m2reg, ex_wmem,
           ex_fwd_a, ex_fwd_b
  );

  modport slave (
    input  stall, flush, id_valid, id_qa, id_qb, id_imm, id_sa, id_rs, id_rt, id_wn,
           id_aluc, id_aluimm, id_shift, id_wreg, id_m2reg, id_wmem,
           em_wreg, em_m2reg, em_wn, em_alu, mw_wreg, mw_wn, mw_result,
    output ex_a, ex_b, ex_aluc, ex_st_data, ex_wn, ex_valid, ex_wreg, ex_m2reg, ex_wmem,
           ex_fwd_a, ex_fwd_b
  );
endinterface

// File: rtl/pipe_idex_operand_stage.sv
// ID/EX pipeline register of the MIPS core: latches decoded operands and control, then
// resolves EX/MEM and MEM/WB forwarding to drive the EX-stage ALU inputs.
module pipe_idex_operand_stage #(
  parameter logic [3:0] NOP_ALUC = 4'b0000
) (
  input logic                         clock,
  input logic                         resetn,
  pipe_idex_operand_stage_if.slave    bus
);

  localparam logic [1:0] SRC_REG = 2'd0;
  localparam logic [1:0] SRC_EM  = 2'd1;
  localparam logic [1:0] SRC_MW  = 2'd2;

  logic        r_valid;
  logic [31:0] r_qa;
  logic [31:0] r_qb;
  logic [31:0] r_imm;
  logic [4:0]  r_sa;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_wn;
  logic [3:0]  r_aluc;
  logic        r_aluimm;
  logic        r_shift;
  logic        r_wreg;
  logic        r_m2reg;
  logic        r_wmem;

  // Edge priority: reset, then flush (bubble, wins over stall), then stall (hold), then load.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid  <= 1'b0;
      r_qa     <= '0;
      r_qb     <= '0;
      r_imm    <= '0;
      r_sa     <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_wn     <= '0;
      r_aluc   <= NOP_ALUC;
      r_aluimm <= 1'b0;
      r_shift  <= 1'b0;
      r_wreg   <= 1'b0;
      r_m2reg  <= 1'b0;
      r_wmem   <= 1'b0;
    end else if (bus.flush) begin
      r_valid  <= 1'b0;
      r_qa     <= '0;
      r_qb     <= '0;
      r_imm    <= '0;
      r_sa     <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_wn     <= '0;
      r_aluc   <= NOP_ALUC;
      r_aluimm <= 1'b0;
      r_shift  <= 1'b0;
      r_wreg   <= 1'b0;
      r_m2reg  <= 1'b0;
      r_wmem   <= 1'b0;
    end else if (!bus.stall) begin
      r_valid  <= bus.id_valid;
      r_qa     <= bus.id_qa;
      r_qb     <= bus.id_qb;
      r_imm    <= bus.id_imm;
      r_sa     <= bus.id_sa;
      r_rs     <= bus.id_rs;
      r_rt     <= bus.id_rt;
      r_wn     <= bus.id_wn;
      r_aluc   <= bus.id_aluc;
      r_aluimm <= bus.id_aluimm;
      r_shift  <= bus.id_shift;
      r_wreg   <= bus.id_wreg  & bus.id_valid;
      r_m2reg  <= bus.id_m2reg & bus.id_valid;
      r_wmem   <= bus.id_wmem  & bus.id_valid;
    end
  end

  // A load in EX/MEM has no data yet; the hazard unit bubbles that case, so it is never a source.
  logic em_fwd_ok;
  logic mw_fwd_ok;
  assign em_fwd_ok = bus.em_wreg & ~bus.em_m2reg & (bus.em_wn != 5'd0);
  assign mw_fwd_ok = bus.mw_wreg & (bus.mw_wn != 5'd0);

  logic [1:0]  sel_a;
  logic [1:0]  sel_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  always_comb begin
    sel_a = SRC_REG;
    fwd_a = r_qa;
    if (em_fwd_ok && (bus.em_wn == r_rs)) begin
      sel_a = SRC_EM;
      fwd_a = bus.em_alu;
    end else if (mw_fwd_ok && (bus.mw_wn == r_rs)) begin
      sel_a = SRC_MW;
      fwd_a = bus.mw_result;
    end
  end

  always_comb begin
    sel_b = SRC_REG;
    fwd_b = r_qb;
    if (em_fwd_ok && (bus.em_wn == r_rt)) begin
      sel_b = SRC_EM;
      fwd_b = bus.em_alu;
    end else if (mw_fwd_ok && (bus.mw_wn == r_rt)) begin
      sel_b = SRC_MW;
      fwd_b = bus.mw_result;
    end
  end

  // Forwarding sources are reported even when shift/aluimm override the operand.
  assign bus.ex_a       = r_shift  ? {27'b0, r_sa} : fwd_a;
  assign bus.ex_b       = r_aluimm ? r_imm : fwd_b;
  assign bus.ex_st_data = fwd_b;
  assign bus.ex_aluc    = r_aluc;
  assign bus.ex_wn      = r_wn;
  assign bus.ex_valid   = r_valid;
  assign bus.ex_wreg    = r_wreg;
  assign bus.ex_m2reg   = r_m2reg;
  assign bus.ex_wmem    = r_wmem;
  assign bus.ex_fwd_a   = sel_a;
  assign bus.ex_fwd_b   = sel_b;

endmodule

// File: tb/tb_pipe_idex_operand_stage.sv
// Directed bench for the ID/EX operand stage: reset, plain load, forwarding priority,
// shift/immediate override, stall/flush and the load-in-EX/MEM exclusion.
module tb_pipe_idex_operand_stage;

  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_err;

  pipe_idex_operand_stage_if bus ();

  pipe_idex_operand_stage #(.NOP_ALUC(4'b0000)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // driver tasks
  task automatic clear_inputs();
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.id_valid  = 1'b0;
    bus.id_qa     = '0;
    bus.id_qb     = '0;
    bus.id_imm    = '0;
    bus.id_sa     = '0;
    bus.id_rs     = '0;
    bus.id_rt     = '0;
    bus.id_wn     = '0;
    bus.id_aluc   = '0;
    bus.id_aluimm = 1'b0;
    bus.id_shift  = 1'b0;
    bus.id_wreg   = 1'b0;
    bus.id_m2reg  = 1'b0;
    bus.id_wmem   = 1'b0;
    bus.em_wreg   = 1'b0;
    bus.em_m2reg  = 1'b0;
    bus.em_wn     = '0;
    bus.em_alu    = '0;
    bus.mw_wreg   = 1'b0;
    bus.mw_wn     = '0;
    bus.mw_result = '0;
  endtask

  task automatic load_id(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] qa,
                         input logic [31:0] qb, input logic [3:0] aluc);
    bus.id_valid = 1'b1;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_qa    = qa;
    bus.id_qb    = qb;
    bus.id_aluc  = aluc;
    bus.id_wn    = 5'd12;
    bus.id_wreg  = 1'b1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    load_id(5'd1, 5'd2, 32'hDEAD, 32'hBEEF, 4'b0110);
    bus.id_wmem = 1'b1;
    bus.id_shift = 1'b1;
    bus.id_sa = 5'd7;
    step();
    @(negedge clock);
    #1;
    resetn = 1'b0;
    #1;
    n_cmp++; if (bus.ex_a !== 32'h0) begin n_err++; $display("FAIL reset_ex_a got %h want %h", bus.ex_a, 32'h0); end
    n_cmp++; if (bus.ex_b !== 32'h0) begin n_err++; $display("FAIL reset_ex_b got %h want %h", bus.ex_b, 32'h0); end
    n_cmp++; if (bus.ex_st_data !== 32'h0) begin n_err++; $display("FAIL reset_st_data got %h want %h", bus.ex_st_data, 32'h0); end
    n_cmp++; if (bus.ex_aluc !== 4'b0000) begin n_err++; $display("FAIL reset_aluc got %b want %b", bus.ex_aluc, 4'b0000); end
    n_cmp++; if ({bus.ex_valid, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl got %b want %b", {bus.ex_valid, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}, 4'b0000);
    end
    n_cmp++; if ({bus.ex_fwd_a, bus.ex_fwd_b, bus.ex_wn} !== 9'h0) begin
      n_err++; $display("FAIL reset_fwd_wn got %h want %h", {bus.ex_fwd_a, bus.ex_fwd_b, bus.ex_wn}, 9'h0);
    end
    @(negedge clock);
    resetn = 1'b1;
    clear_inputs();
  endtask

  task automatic test_plain_add();
    clear_inputs();
    load_id(5'd1, 5'd2, 32'd5, 32'd7, 4'b0000);
    step();
    n_cmp++; if (bus.ex_a !== 32'd5) begin n_err++; $display("FAIL add_a got %h want %h", bus.ex_a, 32'd5); end
    n_cmp++; if (bus.ex_b !== 32'd7) begin n_err++; $display("FAIL add_b got %h want %h", bus.ex_b, 32'd7); end
    n_cmp++; if ({bus.ex_fwd_a, bus.ex_fwd_b} !== 4'b0000) begin
      n_err++; $display("FAIL add_fwd got %b want %b", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b0000);
    end
    n_cmp++; if ({bus.ex_valid, bus.ex_wreg, bus.ex_wn} !== {1'b1, 1'b1, 5'd12}) begin
      n_err++; $display("FAIL add_ctrl got %b want %b", {bus.ex_valid, bus.ex_wreg, bus.ex_wn}, {1'b1, 1'b1, 5'd12});
    end
  endtask

  task automatic test_double_forward();
    clear_inputs();
    load_id(5'd3, 5'd3, 32'hA0, 32'hB0, 4'b0000);
    bus.em_wreg = 1'b1; bus.em_wn = 5'd3; bus.em_alu = 32'h11;
    bus.mw_wreg = 1'b1; bus.mw_wn = 5'd3; bus.mw_result = 32'h22;
    step();
    n_cmp++; if ({bus.ex_a, bus.ex_b} !== {32'h11, 32'h11}) begin
      n_err++; $display("FAIL fwd_em_ab got %h %h want 11 11", bus.ex_a, bus.ex_b);
    end
    n_cmp++; if ({bus.ex_fwd_a, bus.ex_fwd_b} !== 4'b0101) begin
      n_err++; $display("FAIL fwd_em_sel got %b want %b", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b0101);
    end
    bus.em_wreg = 1'b0;
    #1;
    n_cmp++; if ({bus.ex_a, bus.ex_b} !== {32'h22, 32'h22}) begin
      n_err++; $display("FAIL fwd_mw_ab got %h %h want 22 22", bus.ex_a, bus.ex_b);
    end
    n_cmp++; if ({bus.ex_fwd_a, bus.ex_fwd_b} !== 4'b1010) begin
      n_err++; $display("FAIL fwd_mw_sel got %b want %b", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b1010);
    end
    // register 0 must never be forwarded, even with matching writers
    load_id(5'd0, 5'd0, 32'hA, 32'hB, 4'b0000);
    bus.em_wreg = 1'b1; bus.em_wn = 5'd0;
    bus.mw_wn = 5'd0;
    step();
    n_cmp++; if ({bus.ex_a, bus.ex_b} !== {32'hA, 32'hB}) begin
      n_err++; $display("FAIL fwd_r0_ab got %h %h want a b", bus.ex_a, bus.ex_b);
    end
    n_cmp++; if ({bus.ex_fwd_a, bus.ex_fwd_b} !== 4'b0000) begin
      n_err++; $display("FAIL fwd_r0_sel got %b want %b", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b0000);
    end
  endtask

  task automatic test_shift_imm();
    clear_inputs();
    load_id(5'd10, 5'd9, 32'h33, 32'h77, 4'b0101);
    bus.id_shift = 1'b1; bus.id_sa = 5'd4;
    bus.id_aluimm = 1'b1; bus.id_imm = 32'hFFFF0000;
    bus.em_wreg = 1'b1; bus.em_wn = 5'd9; bus.em_alu = 32'h9;
    step();
    n_cmp++; if (bus.ex_a !== 32'd4) begin n_err++; $display("FAIL shift_a got %h want %h", bus.ex_a, 32'd4); end
    n_cmp++; if (bus.ex_b !== 32'hFFFF0000) begin n_err++; $display("FAIL imm_b got %h want %h", bus.ex_b, 32'hFFFF0000); end
    n_cmp++; if (bus.ex_st_data !== 32'h9) begin n_err++; $display("FAIL st_data got %h want %h", bus.ex_st_data, 32'h9); end
    n_cmp++; if ({bus.ex_fwd_a, bus.ex_fwd_b} !== 4'b0001) begin
      n_err++; $display("FAIL shimm_sel got %b want %b", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b0001);
    end
    n_cmp++; if (bus.ex_aluc !== 4'b0101) begin n_err++; $display("FAIL shimm_aluc got %b want %b", bus.ex_aluc, 4'b0101); end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    load_id(5'd4, 5'd5, 32'h100, 32'h200, 4'b0010);
    bus.id_m2reg = 1'b1;
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_id(5'd6, 5'd7, 32'h300 + i, 32'h400 + i, 4'b1111);
      step();
      n_cmp++; if ({bus.ex_a, bus.ex_b} !== {32'h100, 32'h200}) begin
        n_err++; $display("FAIL stall_ab%0d got %h %h want 100 200", i, bus.ex_a, bus.ex_b);
      end
      n_cmp++; if ({bus.ex_aluc, bus.ex_wreg, bus.ex_m2reg} !== {4'b0010, 1'b1, 1'b1}) begin
        n_err++; $display("FAIL stall_ctrl%0d got %b want %b", i, {bus.ex_aluc, bus.ex_wreg, bus.ex_m2reg}, {4'b0010, 1'b1, 1'b1});
      end
    end
    bus.flush = 1'b1;
    step();
    n_cmp++; if ({bus.ex_valid, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem} !== 4'b0000) begin
      n_err++; $display("FAIL flush_ctrl got %b want %b", {bus.ex_valid, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}, 4'b0000);
    end
    n_cmp++; if (bus.ex_aluc !== 4'b0000) begin n_err++; $display("FAIL flush_aluc got %b want %b", bus.ex_aluc, 4'b0000); end
    n_cmp++; if ({bus.ex_a, bus.ex_b, bus.ex_wn} !== 69'h0) begin
      n_err++; $display("FAIL flush_data got %h %h %h want 0", bus.ex_a, bus.ex_b, bus.ex_wn);
    end
    // invalid instruction: writes are gated off even if decode asserted them
    clear_inputs();
    load_id(5'd1, 5'd2, 32'h1, 32'h2, 4'b0000);
    bus.id_valid = 1'b0; bus.id_m2reg = 1'b1; bus.id_wmem = 1'b1;
    step();
    n_cmp++; if ({bus.ex_valid, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem} !== 4'b0000) begin
      n_err++; $display("FAIL invalid_ctrl got %b want %b", {bus.ex_valid, bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem}, 4'b0000);
    end
  endtask

  task automatic test_load_not_forwarded();
    clear_inputs();
    load_id(5'd8, 5'd8, 32'h55, 32'h56, 4'b0000);
    bus.em_wreg = 1'b1; bus.em_m2reg = 1'b1; bus.em_wn = 5'd8; bus.em_alu = 32'h99;
    step();
    n_cmp++; if (bus.ex_a !== 32'h55) begin n_err++; $display("FAIL ld_a got %h want %h", bus.ex_a, 32'h55); end
    n_cmp++; if ({bus.ex_fwd_a, bus.ex_fwd_b} !== 4'b0000) begin
      n_err++; $display("FAIL ld_sel got %b want %b", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b0000);
    end
    bus.mw_wreg = 1'b1; bus.mw_wn = 5'd8; bus.mw_result = 32'h66;
    #1;
    n_cmp++; if ({bus.ex_a, bus.ex_st_data} !== {32'h66, 32'h66}) begin
      n_err++; $display("FAIL ld_mw got %h %h want 66 66", bus.ex_a, bus.ex_st_data);
    end
    n_cmp++; if ({bus.ex_fwd_a, bus.ex_fwd_b} !== 4'b1010) begin
      n_err++; $display("FAIL ld_mw_sel got %b want %b", {bus.ex_fwd_a, bus.ex_fwd_b}, 4'b1010);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    test_reset();
    test_plain_add();
    test_double_forward();
    test_shift_imm();
    test_stall_flush();
    test_load_not_forwarded();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
